// File: rtl/wb_interconnect_decode.sv
// Single-initiator to N-target Wishbone classic-cycle address decoder/router.
// Latches the decoded target, forwards the request to it only and returns its response.
module wb_interconnect_decode #(
  parameter int unsigned N_TARGETS = 4,
  parameter int unsigned ADR_WIDTH = 32,
  parameter int unsigned DAT_WIDTH = 32,
  parameter logic [N_TARGETS*ADR_WIDTH-1:0] T_ADR_BASE = '0,
  parameter logic [N_TARGETS*ADR_WIDTH-1:0] T_ADR_MASK = '0,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ADR_WIDTH-1:0]             i_adr,
  input  logic [DAT_WIDTH-1:0]             i_dat_w,
  output logic [DAT_WIDTH-1:0]             i_dat_r,
  input  logic                             i_cyc,
  input  logic                             i_stb,
  input  logic                             i_we,
  input  logic [DAT_WIDTH/8-1:0]           i_sel,
  output logic                             i_ack,
  output logic                             i_err,
  output logic [ADR_WIDTH-1:0]             t_adr,
  output logic [DAT_WIDTH-1:0]             t_dat_w,
  output logic [DAT_WIDTH/8-1:0]           t_sel,
  output logic                             t_we,
  output logic [N_TARGETS-1:0]             t_cyc,
  output logic [N_TARGETS-1:0]             t_stb,
  input  logic [N_TARGETS*DAT_WIDTH-1:0]   t_dat_r,
  input  logic [N_TARGETS-1:0]             t_ack,
  input  logic [N_TARGETS-1:0]             t_err
);

  localparam int unsigned SEL_W = (N_TARGETS > 1) ? $clog2(N_TARGETS) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_ERROR  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               dec_hit;
  logic [SEL_W-1:0]   dec_idx;
  logic               sel_ack;
  logic               sel_err;
  logic [DAT_WIDTH-1:0] sel_dat;
  logic [N_TARGETS-1:0] sel_oh;
  logic               timeout_hit;

  assign t_adr   = i_adr;
  assign t_dat_w = i_dat_w;
  assign t_sel   = i_sel;
  assign t_we    = i_we;

  // Address decode; scanning downward lets the lowest matching index win
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int i = int'(N_TARGETS) - 1; i >= 0; i--) begin
      if ((i_adr & T_ADR_MASK[i*ADR_WIDTH +: ADR_WIDTH]) == T_ADR_BASE[i*ADR_WIDTH +: ADR_WIDTH]) begin
        dec_hit = 1'b1;
        dec_idx = SEL_W'(i);
      end
    end
  end

  // Response mux from the latched target
  always_comb begin
    sel_ack = 1'b0;
    sel_err = 1'b0;
    sel_dat = '0;
    for (int i = 0; i < int'(N_TARGETS); i++) begin
      if (sel_q == SEL_W'(i)) begin
        sel_ack = t_ack[i];
        sel_err = t_err[i];
        sel_dat = t_dat_r[i*DAT_WIDTH +: DAT_WIDTH];
      end
    end
  end

  assign sel_oh      = N_TARGETS'(1) << sel_q;
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT));

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    t_cyc   = '0;
    t_stb   = '0;
    i_ack   = 1'b0;
    i_err   = 1'b0;
    i_dat_r = '0;
    case (state_q)
      ST_IDLE: begin
        if (i_cyc && i_stb) begin
          if (dec_hit) begin
            sel_d   = dec_idx;
            cnt_d   = '0;
            state_d = ST_ACTIVE;
          end else begin
            state_d = ST_ERROR;
          end
        end
      end
      ST_ACTIVE: begin
        i_dat_r = sel_dat;
        cnt_d   = cnt_q + CNT_W'(1);
        if (!i_cyc) begin
          state_d = ST_IDLE;
        end else if (timeout_hit) begin
          // Target is released this cycle; any response it gives now is ignored
          state_d = ST_ERROR;
        end else begin
          t_cyc = sel_oh;
          t_stb = i_stb ? sel_oh : '0;
          i_ack = sel_ack;
          i_err = sel_err & ~sel_ack;
          if (sel_ack || sel_err) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_ERROR: begin
        i_err   = i_cyc;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_interconnect_decode.sv
// Self-checking bench for wb_interconnect_decode: vector table plus response scoreboard,
// with hand sequences for timeout, abort, overlap priority and mid-transfer reset.
module tb_wb_interconnect_decode;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  adr = '0;
  logic [31:0]  dat_w = '0;
  logic [3:0]   sel = '0;
  logic         cyc = 1'b0;
  logic         stb = 1'b0;
  logic         we = 1'b0;

  logic [31:0]  a_i_dat_r;
  logic         a_i_ack, a_i_err;
  logic [31:0]  a_t_adr, a_t_dat_w;
  logic [3:0]   a_t_sel;
  logic         a_t_we;
  logic [3:0]   a_t_cyc, a_t_stb;
  logic [127:0] a_t_dat_r = '0;
  logic [3:0]   a_t_ack = '0;
  logic [3:0]   a_t_err = '0;

  logic [31:0]  b_i_dat_r;
  logic         b_i_ack, b_i_err;
  logic [31:0]  b_t_adr, b_t_dat_w;
  logic [3:0]   b_t_sel;
  logic         b_t_we;
  logic [3:0]   b_t_cyc, b_t_stb;
  logic [127:0] b_t_dat_r = '0;
  logic [3:0]   b_t_ack = '0;
  logic [3:0]   b_t_err = '0;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  wb_interconnect_decode #(
    .N_TARGETS(4), .ADR_WIDTH(32), .DAT_WIDTH(32),
    .T_ADR_BASE({32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000}),
    .T_ADR_MASK({4{32'hFFFF_F000}}),
    .TIMEOUT(8)
  ) dut_a (
    .clk(clk), .rst(rst),
    .i_adr(adr), .i_dat_w(dat_w), .i_dat_r(a_i_dat_r),
    .i_cyc(cyc), .i_stb(stb), .i_we(we), .i_sel(sel),
    .i_ack(a_i_ack), .i_err(a_i_err),
    .t_adr(a_t_adr), .t_dat_w(a_t_dat_w), .t_sel(a_t_sel), .t_we(a_t_we),
    .t_cyc(a_t_cyc), .t_stb(a_t_stb),
    .t_dat_r(a_t_dat_r), .t_ack(a_t_ack), .t_err(a_t_err)
  );

  // Overlapping map: targets 0 and 1 both cover 0x0000_0xxx
  wb_interconnect_decode #(
    .N_TARGETS(4), .ADR_WIDTH(32), .DAT_WIDTH(32),
    .T_ADR_BASE({32'h8000_0000, 32'h0000_9000, 32'h0000_0000, 32'h0000_0000}),
    .T_ADR_MASK({32'h8000_0000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_0000}),
    .TIMEOUT(255)
  ) dut_b (
    .clk(clk), .rst(rst),
    .i_adr(adr), .i_dat_w(dat_w), .i_dat_r(b_i_dat_r),
    .i_cyc(cyc), .i_stb(stb), .i_we(we), .i_sel(sel),
    .i_ack(b_i_ack), .i_err(b_i_err),
    .t_adr(b_t_adr), .t_dat_w(b_t_dat_w), .t_sel(b_t_sel), .t_we(b_t_we),
    .t_cyc(b_t_cyc), .t_stb(b_t_stb),
    .t_dat_r(b_t_dat_r), .t_ack(b_t_ack), .t_err(b_t_err)
  );

  typedef struct {
    logic        ack;
    logic        err;
    logic [31:0] dat;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          idx;     // -1: unmapped
    int          kind;    // 0: target acks, 1: target errors
    int          wait_n;  // wait states before the target responds
    logic [31:0] rdat;
    logic [3:0]  exp_stb;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, exp, cyc_cnt);
    end
  endtask

  // Response monitor: every initiator ack/err must match the next scoreboard entry
  always @(negedge clk) begin
    if (!rst && (a_i_ack || a_i_err)) begin
      chk("ack_err_exclusive", 32'(a_i_ack & a_i_err), 32'd0);
      if (sb.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_resp: got ack=%0b err=%0b at cycle %0d, required no response",
                 a_i_ack, a_i_err, cyc_cnt);
      end else begin
        mon_e = sb.pop_front();
        chk("resp_ack", 32'(a_i_ack), 32'(mon_e.ack));
        chk("resp_err", 32'(a_i_err), 32'(mon_e.err));
        chk("resp_dat", a_i_dat_r, mon_e.dat);
        chk("resp_cycle", 32'(cyc_cnt), 32'(mon_e.cyc));
      end
    end
  end

  task automatic drop_all();
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    a_t_ack = '0; a_t_err = '0; a_t_dat_r = '0;
  endtask

  task automatic check_drained();
    @(negedge clk);
    chk("resp_pending", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   lat;
    int   c0;
    lat = (v.idx < 0) ? 1 : 1 + v.wait_n;
    @(posedge clk); #1;
    adr = v.adr; we = v.we; dat_w = v.dat; sel = v.sel; cyc = 1'b1; stb = 1'b1;
    c0 = cyc_cnt;
    e.ack = (v.idx >= 0) && (v.kind == 0);
    e.err = (v.idx < 0) || (v.kind == 1);
    e.dat = (v.idx < 0) ? 32'h0 : v.rdat;
    e.cyc = c0 + lat;
    sb.push_back(e);
    @(negedge clk);
    chk("decode_cycle_stb", 32'(a_t_stb), 32'd0);
    for (int j = 1; j <= lat; j++) begin
      @(posedge clk); #1;
      if (v.idx >= 0 && j == lat) begin
        a_t_ack[v.idx] = (v.kind == 0);
        a_t_err[v.idx] = (v.kind == 1);
        a_t_dat_r[v.idx*32 +: 32] = v.rdat;
      end
      @(negedge clk);
      chk("t_stb", 32'(a_t_stb), 32'(v.exp_stb));
      chk("t_cyc", 32'(a_t_cyc), 32'(v.exp_stb));
      if (j == 1) begin
        chk("t_adr", a_t_adr, v.adr);
        chk("t_we", 32'(a_t_we), 32'(v.we));
        chk("t_dat_w", a_t_dat_w, v.dat);
        chk("t_sel", 32'(a_t_sel), 32'(v.sel));
      end
    end
    drop_all();
    check_drained();
  endtask

  initial begin
    exp_t e;
    int   c0;

    vecs[0] = '{32'h0000_2004, 1'b0, 32'h0,         4'hF,  2, 0, 0, 32'hCAFE_F00D, 4'b0100};
    vecs[1] = '{32'h0000_1010, 1'b1, 32'h1234_5678, 4'h3,  1, 0, 0, 32'h0,         4'b0010};
    vecs[2] = '{32'h0000_9000, 1'b0, 32'h0,         4'hF, -1, 0, 0, 32'h0,         4'b0000};
    vecs[3] = '{32'h0000_0FFC, 1'b0, 32'h0,         4'hF,  0, 0, 2, 32'h1111_0000, 4'b0001};
    vecs[4] = '{32'h0000_3ABC, 1'b0, 32'h0,         4'hF,  3, 1, 1, 32'h55AA_55AA, 4'b1000};
    vecs[5] = '{32'h0000_4000, 1'b1, 32'hFFFF_0000, 4'hC, -1, 0, 0, 32'h0,         4'b0000};
    vecs[6] = '{32'h0000_0000, 1'b1, 32'hA5A5_A5A5, 4'hF,  0, 0, 0, 32'h0,         4'b0001};
    vecs[7] = '{32'h0000_2FF0, 1'b0, 32'h0,         4'h1,  2, 0, 4, 32'h0BAD_BEEF, 4'b0100};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_t_cyc", 32'(a_t_cyc), 32'd0);
    chk("reset_t_stb", 32'(a_t_stb), 32'd0);
    chk("reset_i_ack", 32'(a_i_ack), 32'd0);
    chk("reset_i_err", 32'(a_i_err), 32'd0);
    chk("reset_i_dat_r", a_i_dat_r, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int k = 0; k < 8; k++) run_vec(vecs[k]);

    // Overlap priority: 0x0100 hits targets 0 and 1 of dut_b, target 0 wins
    @(posedge clk); #1;
    adr = 32'h0000_0100; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("overlap_t_stb", 32'(b_t_stb), 32'b0001);
    chk("overlap_t_cyc", 32'(b_t_cyc), 32'b0001);
    drop_all();
    @(negedge clk);
    chk("overlap_release", 32'(b_t_cyc), 32'd0);
    sb.delete();

    // Timeout: target 2 never answers
    @(posedge clk); #1;
    adr = 32'h0000_2100; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    c0 = cyc_cnt;
    e.ack = 1'b0; e.err = 1'b1; e.dat = 32'h0; e.cyc = c0 + 10;
    sb.push_back(e);
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      if (j > 1) chk("to_t_stb_held", 32'(a_t_stb), 32'b0100);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("to_t_stb_held", 32'(a_t_stb), 32'b0100);
    @(posedge clk); #1;
    @(negedge clk);
    chk("to_t_stb_release", 32'(a_t_stb), 32'd0);
    chk("to_t_cyc_release", 32'(a_t_cyc), 32'd0);
    @(posedge clk); #1;
    a_t_ack[2] = 1'b1;
    a_t_dat_r[64 +: 32] = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("to_err_cycle_no_ack", 32'(a_i_ack), 32'd0);
    @(posedge clk); #1;
    stb = 1'b0;
    @(negedge clk);
    chk("to_late_ack_ignored", 32'(a_i_ack), 32'd0);
    chk("to_late_no_err", 32'(a_i_err), 32'd0);
    chk("to_late_no_stb", 32'(a_t_stb), 32'd0);
    drop_all();
    check_drained();

    // Initiator abort on the third ACTIVE cycle
    @(posedge clk); #1;
    adr = 32'h0000_3000; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    for (int j = 1; j <= 2; j++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("abort_t_cyc_before", 32'(a_t_cyc), 32'b1000);
    end
    @(posedge clk); #1;
    cyc = 1'b0;
    a_t_ack[3] = 1'b1;
    @(negedge clk);
    chk("abort_t_cyc", 32'(a_t_cyc), 32'd0);
    chk("abort_t_stb", 32'(a_t_stb), 32'd0);
    chk("abort_no_ack", 32'(a_i_ack), 32'd0);
    chk("abort_no_err", 32'(a_i_err), 32'd0);
    drop_all();
    @(negedge clk);
    chk("abort_idle_t_cyc", 32'(a_t_cyc), 32'd0);
    check_drained();

    // Synchronous reset in the middle of a transfer
    @(posedge clk); #1;
    adr = 32'h0000_1000; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    a_t_dat_r[32 +: 32] = 32'h7777_7777;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_pre_t_stb", 32'(a_t_stb), 32'b0010);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_sync_t_stb", 32'(a_t_stb), 32'b0010);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_t_cyc", 32'(a_t_cyc), 32'd0);
    chk("rst_t_stb", 32'(a_t_stb), 32'd0);
    chk("rst_i_dat_r", a_i_dat_r, 32'd0);
    chk("rst_i_ack", 32'(a_i_ack), 32'd0);
    chk("rst_i_err", 32'(a_i_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    a_t_dat_r = '0;
    check_drained();

    run_vec(vecs[0]);
    run_vec(vecs[2]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/wb_interconnect_decode.md
# wb_interconnect_decode

Single-initiator to N-target Wishbone address decoder/router: the one-to-many counterpart of `wb_interconnect_arb`, which resolves many-to-one. It latches the target selected by the initiator address, forwards the classic-cycle request to that target only, and returns that target's response. Unmapped addresses and hung targets produce a Wishbone error. It sits between a wb_interconnect_arb-granted initiator port and the target ports of the fw-wishbone-interconnect.

## Interface
- N_TARGETS, 4, number of target ports (1..16)
- ADR_WIDTH, 32, address width
- DAT_WIDTH, 32, data width; byte-select width is DAT_WIDTH/8
- T_ADR_BASE, 0, N_TARGETS×ADR_WIDTH packed base addresses; target i occupies slice i
- T_ADR_MASK, 0, N_TARGETS×ADR_WIDTH packed masks; target i matches when (adr & mask_i) == base_i
- TIMEOUT, 255, cycles in ACTIVE without ack/err before an error is forced (≥1)

Ports:
- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  reset, synchronous, active-high
- i_adr  in  ADR_WIDTH  initiator address
- i_dat_w  in  DAT_WIDTH  initiator write data
- i_dat_r  out  DAT_WIDTH  read data returned to the initiator
- i_cyc, i_stb, i_we  in  1 each  initiator cycle, strobe and write enable
- i_sel  in  DAT_WIDTH/8  initiator byte selects
- i_ack, i_err  out  1 each  initiator acknowledge and error
- t_adr  out  ADR_WIDTH  broadcast to all targets
- t_dat_w  out  DAT_WIDTH  broadcast to all targets
- t_sel  out  DAT_WIDTH/8  broadcast to all targets
- t_we  out  1  broadcast to all targets
- t_cyc, t_stb  out  N_TARGETS each  per-target cycle and strobe (one-hot or zero)
- t_dat_r  in  N_TARGETS×DAT_WIDTH  packed target read data
- t_ack, t_err  in  N_TARGETS each  per-target acknowledge and error

## Operation
- States: IDLE, ACTIVE, ERROR. After reset the block is in IDLE.
- Reset values: sel_q = 0, timeout counter = 0, t_cyc = 0, t_stb = 0, i_ack = 0, i_err = 0, i_dat_r = 0.
- Broadcast outputs t_adr, t_dat_w, t_sel and t_we follow the initiator inputs combinationally.
- IDLE with i_cyc & i_stb:
  - Evaluate all N_TARGETS matches. The lowest matching index wins when ranges overlap.
  - On a match: sel_q ← index, counter ← 0, next state ACTIVE.
  - On no match: next state ERROR.
- ACTIVE:
  - t_cyc[sel_q] = i_cyc and t_stb[sel_q] = i_stb. All other target bits are 0.
  - i_ack = t_ack[sel_q] & i_cyc. i_err = t_err[sel_q] & i_cyc. i_dat_r = t_dat_r[sel_q]. These are combinational pass-throughs.
  - A cycle with t_ack[sel_q] or t_err[sel_q] returns the state to IDLE. An acknowledged target is never re-strobed in the same transaction.
  - If i_cyc drops (initiator abort), the target's cyc drops the same cycle and the state returns to IDLE. No response is given.
  - The counter increments each ACTIVE cycle. When counter == TIMEOUT with no target response:
    - t_cyc and t_stb are forced to 0 from that cycle on.
    - The state moves to ERROR.
- ERROR:
  - i_err = 1 for exactly one cycle, then the state returns to IDLE.
  - t_cyc and t_stb are 0.
  - If i_cyc is already low, i_err is suppressed.
- i_ack and i_err are never asserted together, and never asserted outside a response cycle.
- i_dat_r = 0 when not in ACTIVE.
- Reset asserted in any state: the block is in IDLE on the next edge, all outputs take their reset values, and any pending target transaction is abandoned.

## Timing
- Decode latency: 1 cycle. The request seen in IDLE at edge n drives t_stb from cycle n+1.
- Earliest i_ack is cycle n+1, when a zero-wait target acks combinationally.
- Unmapped address: i_err in cycle n+1.
- Timeout: i_err at cycle n+1+TIMEOUT+1.
- Back-to-back transfers: after the response cycle the block is in IDLE, so the next strobe costs one decode cycle. Sustained throughput is at most one transfer per 2 cycles.
- Target-side inputs are sampled only when in ACTIVE. Responses in IDLE or ERROR are ignored.

## Test plan
- Decode hit, single read: bases 0x0000/0x1000/0x2000/0x3000, masks 0xFFFFF000. The initiator reads 0x2004.
  - Required: t_stb = 4'b0100 from the cycle after the strobe.
  - Target 2 returns 0xCAFEF00D with ack → i_ack = 1 and i_dat_r = 0xCAFEF00D the same cycle. State back to IDLE.
- Write broadcast: write 0x1010 with data 0x12345678, sel 4'b0011.
  - Required: t_stb = 4'b0010, t_we = 1, t_dat_w = 0x12345678, t_sel = 4'b0011. Other targets see stb = 0.
- Unmapped address: read 0x9000 → t_stb stays 0, and i_err = 1 for one cycle, one cycle after the strobe.
- Overlap priority: bases 0x0 and 0x0 with masks 0xFFFF0000 and 0xFFFFF000, access 0x0100 → target 0 is selected.
- Timeout: TIMEOUT = 8 and the target never responds → i_err at cycle 10 after the strobe, t_cyc/t_stb = 0 from cycle 9. A late t_ack afterwards is ignored.
- Abort and reset:
  - i_cyc dropped at cycle 3 of ACTIVE → t_cyc = 0 the same cycle, no i_ack/i_err, IDLE next.
  - rst asserted mid-ACTIVE → all outputs 0 on the next edge, and the next access decodes normally.
